// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths and the memory-to-writeback control payload.
package cpu_pkg;

   localparam int unsigned XLEN      = 19;
   localparam int unsigned DMEM_AW   = 8;
   localparam int unsigned REG_AW    = 3;
   localparam int unsigned FAULT_W   = 8;
   localparam logic [FAULT_W-1:0] FAULT_MAX = '1;

   // Control fields carried alongside the data through the M->W register.
   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic              regwrite;
      logic              resultsrc;
   } mw_ctrl_t;

   localparam mw_ctrl_t MW_CTRL_RST = '{rd: '0, regwrite: 1'b0, resultsrc: 1'b0};

endpackage : cpu_pkg

// File: rtl/data_mem.sv
// Single-port data memory: synchronous write, registered read-first read.
module data_mem #(
   parameter int unsigned WIDTH = cpu_pkg::XLEN,
   parameter int unsigned AW    = cpu_pkg::DMEM_AW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we_i,
   input  logic             rd_clr_i,
   input  logic [AW-1:0]    addr_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;
   logic [WIDTH-1:0] rdata_d;

   // Array has no reset: contents survive rst; the caller gates we_i.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   always_comb begin
      rdata_d = mem_q[addr_i];
      if (rd_clr_i) begin
         rdata_d = '0;
      end
   end

   // Read register samples pre-write contents, giving read-first behaviour.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata_o = rdata_q;

endmodule : data_mem

// File: rtl/memory_cycle.sv
// Memory pipeline stage: data memory access, M->W register, writeback mux and fault tracking.
module memory_cycle #(
   parameter int unsigned XLEN    = cpu_pkg::XLEN,
   parameter int unsigned DMEM_AW = cpu_pkg::DMEM_AW
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [XLEN-1:0]             aluresultM,
   input  logic [XLEN-1:0]             writedata,
   input  logic [cpu_pkg::REG_AW-1:0]  rdM,
   input  logic                        regwriteM,
   input  logic                        resultsrcM,
   input  logic                        memwriteM,
   output logic [XLEN-1:0]             resultW,
   output logic [cpu_pkg::REG_AW-1:0]  rdW,
   output logic                        regwriteW,
   output logic                        memfault,
   output logic [cpu_pkg::FAULT_W-1:0] faultcount
);

   import cpu_pkg::mw_ctrl_t;
   import cpu_pkg::MW_CTRL_RST;
   import cpu_pkg::FAULT_W;
   import cpu_pkg::FAULT_MAX;

   logic                in_range;
   logic                access_ev;
   logic                fault_ev;
   logic                mem_we;
   logic [XLEN-1:0]     readdata;

   mw_ctrl_t            ctrl_d;
   mw_ctrl_t            ctrl_q;
   logic [XLEN-1:0]     aluresult_d;
   logic [XLEN-1:0]     aluresult_q;
   logic                memfault_d;
   logic                memfault_q;
   logic [FAULT_W-1:0]  faultcount_d;
   logic [FAULT_W-1:0]  faultcount_q;

   // Address is in range only when every bit above the word index is clear.
   if (XLEN > DMEM_AW) begin : g_range
      assign in_range = (aluresultM[XLEN-1:DMEM_AW] == '0);
   end else begin : g_full
      assign in_range = 1'b1;
   end

   assign access_ev = memwriteM | resultsrcM;
   assign fault_ev  = access_ev & ~in_range;
   assign mem_we    = memwriteM & in_range & rst;

   data_mem #(
      .WIDTH (XLEN),
      .AW    (DMEM_AW)
   ) u_data_mem (
      .clk      (clk),
      .rst      (rst),
      .we_i     (mem_we),
      .rd_clr_i (~in_range),
      .addr_i   (aluresultM[DMEM_AW-1:0]),
      .wdata_i  (writedata),
      .rdata_o  (readdata)
   );

   always_comb begin
      ctrl_d           = MW_CTRL_RST;
      ctrl_d.rd        = rdM;
      ctrl_d.regwrite  = regwriteM;
      ctrl_d.resultsrc = resultsrcM;
      aluresult_d      = aluresultM;
      memfault_d       = memfault_q;
      faultcount_d     = faultcount_q;
      if (fault_ev) begin
         memfault_d = 1'b1;
         if (faultcount_q != FAULT_MAX) begin
            faultcount_d = faultcount_q + FAULT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ctrl_q       <= MW_CTRL_RST;
         aluresult_q  <= '0;
         memfault_q   <= 1'b0;
         faultcount_q <= '0;
      end else begin
         ctrl_q       <= ctrl_d;
         aluresult_q  <= aluresult_d;
         memfault_q   <= memfault_d;
         faultcount_q <= faultcount_d;
      end
   end

   // Writeback select sits after the W register, so resultW follows it combinationally.
   assign resultW    = ctrl_q.resultsrc ? readdata : aluresult_q;
   assign rdW        = ctrl_q.rd;
   assign regwriteW  = ctrl_q.regwrite;
   assign memfault   = memfault_q;
   assign faultcount = faultcount_q;

endmodule : memory_cycle

// File: doc/memory_cycle.md
MEMORY_CYCLE -- requirements
Module: memory_cycle

Interface
REQ-001 Parameter XLEN, default 19: datapath width.
REQ-002 Parameter DMEM_AW, default 8: data-memory word-address width (256 words).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 aluresultM  input  XLEN  memory word address for loads/stores, or the ALU result for writeback.
REQ-006 writedata  input  XLEN  store data.
REQ-007 rdM  input  3  destination register index.
REQ-008 regwriteM  input  1  instruction writes the register file.
REQ-009 resultsrcM  input  1  1 = load (result from memory), 0 = ALU result.
REQ-010 memwriteM  input  1  store enable.
REQ-011 resultW  output  XLEN  writeback value.
REQ-012 rdW  output  3  writeback destination.
REQ-013 regwriteW  output  1  writeback enable.
REQ-014 memfault  output  1  sticky out-of-range access flag.
REQ-015 faultcount  output  8  count of out-of-range accesses, saturating at 255.

Function
REQ-016 The block SHALL contain a 2^DMEM_AW x XLEN data memory addressed by aluresultM[DMEM_AW-1:0].
REQ-017 An access SHALL be in range iff aluresultM[XLEN-1:DMEM_AW] == 0.
REQ-018 When memwriteM=1 and the access is in range, the block SHALL write writedata to memory at the rising edge.
REQ-019 An out-of-range store SHALL leave memory unchanged.
REQ-020 Memory read SHALL be synchronous: readdata is registered at the same edge as the M->W register.
REQ-021 An out-of-range load SHALL register readdata = 0.
REQ-022 A store at edge N followed by a load of the same address at edge N+1 SHALL return the stored value.
REQ-023 The M->W register SHALL capture aluresultM, rdM, regwriteM and resultsrcM every non-reset edge; latency is 1 cycle.
REQ-024 resultW SHALL equal the registered readdata when resultsrcW=1, else the registered aluresult (combinational mux after the W register).
REQ-025 A store (memwriteM=1) SHALL NOT assert regwriteW unless regwriteM was 1; the block SHALL pass regwriteM through unmodified.
REQ-026 An access is an "access event" when memwriteM=1 or resultsrcM=1.
REQ-027 An out-of-range access event SHALL set memfault=1 at that edge; memfault stays 1 until reset.
REQ-028 Each out-of-range access event SHALL increment faultcount by 1 at that edge; at 255 it holds.
REQ-029 A non-access instruction with out-of-range aluresultM SHALL NOT affect memfault or faultcount.
REQ-030 Simultaneous memwriteM=1 and resultsrcM=1 SHALL perform the store, register the pre-write memory contents as readdata (read-first), and count as one event.

Reset
REQ-031 When rst=0 at an edge, resultW, rdW, regwriteW, memfault and faultcount SHALL become 0, and the internal resultsrcW, aluresultW and readdata registers SHALL become 0.
REQ-032 Memory contents SHALL NOT be altered by reset.
REQ-033 A store presented in the same cycle as rst=0 SHALL be suppressed.

Structure
REQ-034 XLEN, DMEM_AW and the register-index width (3) SHALL be defined in the shared package cpu_pkg.
REQ-035 The memory array SHALL be a sub-module data_mem (single-port, synchronous write, registered read-first read), instantiated once.

Verification
REQ-036 Store 19'h1ABCD to address 5, then load address 5 with rdM=3 and regwriteM=1 -> one cycle later resultW=19'h1ABCD, rdW=3, regwriteW=1.
REQ-037 ALU op with aluresultM=19'h00042, resultsrcM=0, regwriteM=1, rdM=7 -> next cycle resultW=19'h00042, rdW=7.
REQ-038 Store 19'h7 to aluresultM=19'h00100 (out of range) -> memory address 0 unchanged, memfault=1, faultcount=1.
REQ-039 Issue 300 consecutive out-of-range loads -> resultW=0 each cycle, faultcount saturates at 255.
REQ-040 Store 19'h55 to address 9, assert rst=0 for one cycle, then load address 9 -> outputs are 0 during reset, memfault=0, and the load returns 19'h55.
REQ-041 Non-access instruction with aluresultM=19'h7FFFF -> memfault stays 0, resultW=19'h7FFFF.
